// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the rPLL startup/supervision sequencer.
// Also holds the helper used to size the shared down-counter.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      RST_PLL   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      PHASE     = 3'd4
   } state_t;

   localparam int PSDA_W = 4;
   localparam logic [PSDA_W-1:0] DUTYDA_DEFAULT = 4'b1000;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // The counter is loaded with N-1, so clog2(N) bits always suffice; never below 1 bit.
   function automatic int cnt_width(input int max_val);
      return (max_val <= 2) ? 1 : $clog2(max_val);
   endfunction

endpackage

// File: rtl/pll_sequencer_sync2.sv
// Generic two-flop synchronizer for asynchronous level inputs.
// Both stages clear on reset so a stale level is never seen after restart.
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_sequencer.sv
// rPLL startup and supervision: reset pulse, lock qualification, system reset release,
// PSDA phase changes via req/ack, and automatic restart on lock loss.
module pll_sequencer
   import pll_seq_pkg::*;
#(
   parameter int                RESET_PULSE_CYCLES  = 16,
   parameter int                LOCK_TIMEOUT_CYCLES = 65535,
   parameter int                LOCK_STABLE_CYCLES  = 1024,
   parameter int                SETTLE_CYCLES       = 8,
   parameter logic [PSDA_W-1:0] DUTYDA_INIT         = DUTYDA_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pll_lock,
   output logic              pll_reset,
   output logic [PSDA_W-1:0] pll_psda,
   output logic [PSDA_W-1:0] pll_dutyda,
   input  logic              phase_req,
   input  logic [PSDA_W-1:0] phase_val,
   output logic              phase_ack,
   output logic              sys_rst,
   output logic              locked,
   output logic              fault,
   output logic [7:0]        relock_cnt
);

   localparam int CNT_MAX = max_of(max_of(RESET_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES),
                                   max_of(LOCK_STABLE_CYCLES, SETTLE_CYCLES));
   localparam int CNT_W   = cnt_width(CNT_MAX);

   // Every state stays resident for exactly N cycles, so the counter is loaded with N-1.
   localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RESET_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             lock_s;
   logic             cnt_done;

   sync2 #(.WIDTH(1)) u_lock_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pll_lock),
      .q     (lock_s)
   );

   assign cnt_done = (cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RST_PLL;
         cnt        <= RST_LOAD;
         pll_reset  <= 1'b1;
         sys_rst    <= 1'b1;
         locked     <= 1'b0;
         pll_psda   <= '0;
         pll_dutyda <= DUTYDA_INIT;
         phase_ack  <= 1'b0;
         fault      <= 1'b0;
         relock_cnt <= '0;
      end else begin
         phase_ack  <= 1'b0;
         pll_dutyda <= DUTYDA_INIT;

         case (state)
            RST_PLL: begin
               if (cnt_done) begin
                  state     <= WAIT_LOCK;
                  cnt       <= TIMEOUT_LOAD;
                  pll_reset <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            WAIT_LOCK: begin
               if (lock_s) begin
                  state <= STABLE;
                  cnt   <= STABLE_LOAD;
               end else if (cnt_done) begin
                  // Retry forever; fault stays set so software can see the PLL struggled.
                  fault     <= 1'b1;
                  state     <= RST_PLL;
                  cnt       <= RST_LOAD;
                  pll_reset <= 1'b1;
                  sys_rst   <= 1'b1;
                  locked    <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            STABLE: begin
               if (!lock_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= TIMEOUT_LOAD;
               end else if (cnt_done) begin
                  state   <= RUN;
                  cnt     <= '0;
                  sys_rst <= 1'b0;
                  locked  <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            RUN: begin
               if (!lock_s) begin
                  state     <= RST_PLL;
                  cnt       <= RST_LOAD;
                  pll_reset <= 1'b1;
                  sys_rst   <= 1'b1;
                  locked    <= 1'b0;
                  if (relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
               end else if (phase_req) begin
                  state    <= PHASE;
                  cnt      <= SETTLE_LOAD;
                  pll_psda <= phase_val;
               end
            end

            PHASE: begin
               // Losing lock mid-settle aborts without an ack; the new PSDA is kept for relock.
               if (!lock_s) begin
                  state     <= RST_PLL;
                  cnt       <= RST_LOAD;
                  pll_reset <= 1'b1;
                  sys_rst   <= 1'b1;
                  locked    <= 1'b0;
                  if (relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
               end else if (cnt_done) begin
                  state     <= RUN;
                  cnt       <= '0;
                  phase_ack <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            default: begin
               state     <= RST_PLL;
               cnt       <= RST_LOAD;
               pll_reset <= 1'b1;
               sys_rst   <= 1'b1;
               locked    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_sequencer.sv
// Scoreboard bench for pll_sequencer: stimulus queues every expected output change
// (cycle number plus full output snapshot); a monitor pops one entry per observed change.
module tb_pll_sequencer;

   localparam int RP = 4;
   localparam int TO = 32;
   localparam int ST = 8;
   localparam int SE = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pll_lock = 1'b0;
   logic       phase_req = 1'b0;
   logic [3:0] phase_val = 4'h0;
   logic       pll_reset;
   logic [3:0] pll_psda;
   logic [3:0] pll_dutyda;
   logic       phase_ack;
   logic       sys_rst;
   logic       locked;
   logic       fault;
   logic [7:0] relock_cnt;

   pll_sequencer #(
      .RESET_PULSE_CYCLES  (RP),
      .LOCK_TIMEOUT_CYCLES (TO),
      .LOCK_STABLE_CYCLES  (ST),
      .SETTLE_CYCLES       (SE),
      .DUTYDA_INIT         (4'b1000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pll_lock   (pll_lock),
      .pll_reset  (pll_reset),
      .pll_psda   (pll_psda),
      .pll_dutyda (pll_dutyda),
      .phase_req  (phase_req),
      .phase_val  (phase_val),
      .phase_ack  (phase_ack),
      .sys_rst    (sys_rst),
      .locked     (locked),
      .fault      (fault),
      .relock_cnt (relock_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic       pll_reset;
      logic       sys_rst;
      logic       locked;
      logic       phase_ack;
      logic       fault;
      logic [3:0] psda;
      logic [7:0] relock;
      logic [3:0] duty;
   } snap_t;

   typedef struct {
      int    cyc;
      snap_t s;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   ev_idx = 0;

   function automatic snap_t mk(input logic pr, input logic sr, input logic lk,
                                input logic ack, input logic flt,
                                input logic [3:0] psda, input logic [7:0] rc);
      snap_t s;
      s.pll_reset = pr;
      s.sys_rst   = sr;
      s.locked    = lk;
      s.phase_ack = ack;
      s.fault     = flt;
      s.psda      = psda;
      s.relock    = rc;
      s.duty      = 4'b1000;
      return s;
   endfunction

   task automatic push(input int c, input snap_t s);
      exp_t e;
      e.cyc = c;
      e.s   = s;
      exp_q.push_back(e);
   endtask

   task automatic at_edge(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   // Monitor: any change in the output snapshot is one transaction.
   snap_t prev_s;
   snap_t now_s;
   exp_t  got_e;
   initial begin
      prev_s = 'x;
      forever begin
         @(negedge clk);
         if (cyc >= 1) begin
            now_s = {pll_reset, sys_rst, locked, phase_ack, fault, pll_psda, relock_cnt, pll_dutyda};
            if (now_s !== prev_s) begin
               ev_idx++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL ev%0d unexpected: cyc=%0d got outputs=%h, required no change", ev_idx, cyc, now_s);
               end else begin
                  got_e = exp_q.pop_front();
                  checks++;
                  if (cyc != got_e.cyc) begin
                     errors++;
                     $display("FAIL ev%0d cycle: got %0d required %0d", ev_idx, cyc, got_e.cyc);
                  end
                  checks++;
                  if (now_s !== got_e.s) begin
                     errors++;
                     $display("FAIL ev%0d outputs at cyc %0d: got %h required %h", ev_idx, cyc, now_s, got_e.s);
                  end
                  $display("ev%0d cyc=%0d rst=%b sys_rst=%b locked=%b ack=%b fault=%b psda=%h relock=%0d",
                           ev_idx, cyc, pll_reset, sys_rst, locked, phase_ack, fault, pll_psda, relock_cnt);
               end
            end
            prev_s = now_s;
         end
      end
   end

   initial begin
      // Reset state, then pll_reset falls RP edges after the last reset edge (edge 3).
      push(1, mk(1, 1, 0, 0, 0, 4'h0, 8'd0));
      push(3 + RP, mk(0, 1, 0, 0, 0, 4'h0, 8'd0));
      at_edge(3);
      reset = 1'b0;

      // Clean startup: lock first sampled at edge 17, release at 17+ST+2.
      push(27, mk(0, 0, 1, 0, 0, 4'h0, 8'd0));
      at_edge(16);
      pll_lock = 1'b1;

      // Phase request 6: psda at 31, one-cycle ack at 35.
      push(31, mk(0, 0, 1, 0, 0, 4'h6, 8'd0));
      push(35, mk(0, 0, 1, 1, 0, 4'h6, 8'd0));
      push(36, mk(0, 0, 1, 0, 0, 4'h6, 8'd0));
      at_edge(30);
      phase_req = 1'b1;
      phase_val = 4'h6;
      at_edge(35);
      phase_req = 1'b0;

      // Lock lost during PHASE: no ack, relock keeps psda=9, held request serviced after RUN.
      push(41, mk(0, 0, 1, 0, 0, 4'h9, 8'd0));
      push(44, mk(1, 1, 0, 0, 0, 4'h9, 8'd1));
      push(48, mk(0, 1, 0, 0, 0, 4'h9, 8'd1));
      push(60, mk(0, 0, 1, 0, 0, 4'h9, 8'd1));
      push(65, mk(0, 0, 1, 1, 0, 4'h9, 8'd1));
      push(66, mk(0, 0, 1, 0, 0, 4'h9, 8'd1));
      at_edge(40);
      phase_req = 1'b1;
      phase_val = 4'h9;
      at_edge(41);
      pll_lock = 1'b0;
      at_edge(49);
      pll_lock = 1'b1;
      at_edge(65);
      phase_req = 1'b0;

      // Lock loss and request in the same RUN cycle: loss wins, psda untouched.
      // Then an unstable relock (5 high, 1 low, high): release 10 edges after edge 86.
      push(73, mk(1, 1, 0, 0, 0, 4'h9, 8'd2));
      push(77, mk(0, 1, 0, 0, 0, 4'h9, 8'd2));
      push(96, mk(0, 0, 1, 0, 0, 4'h9, 8'd2));
      at_edge(70);
      pll_lock = 1'b0;
      at_edge(72);
      phase_req = 1'b1;
      phase_val = 4'hC;
      at_edge(73);
      phase_req = 1'b0;
      at_edge(79);
      pll_lock = 1'b1;
      at_edge(84);
      pll_lock = 1'b0;
      at_edge(85);
      pll_lock = 1'b1;

      // Third lock loss from RUN, then relock.
      push(103, mk(1, 1, 0, 0, 0, 4'h9, 8'd3));
      push(107, mk(0, 1, 0, 0, 0, 4'h9, 8'd3));
      push(120, mk(0, 0, 1, 0, 0, 4'h9, 8'd3));
      at_edge(100);
      pll_lock = 1'b0;
      at_edge(109);
      pll_lock = 1'b1;

      // Mid-operation reset clears counters and psda; lock then stays low -> timeouts every RP+TO.
      push(123, mk(1, 1, 0, 0, 0, 4'h0, 8'd0));
      push(127, mk(0, 1, 0, 0, 0, 4'h0, 8'd0));
      push(159, mk(1, 1, 0, 0, 1, 4'h0, 8'd0));
      push(163, mk(0, 1, 0, 0, 1, 4'h0, 8'd0));
      push(195, mk(1, 1, 0, 0, 1, 4'h0, 8'd0));
      push(199, mk(0, 1, 0, 0, 1, 4'h0, 8'd0));
      push(231, mk(1, 1, 0, 0, 1, 4'h0, 8'd0));
      push(235, mk(0, 1, 0, 0, 1, 4'h0, 8'd0));
      at_edge(122);
      reset    = 1'b1;
      pll_lock = 1'b0;
      at_edge(123);
      reset = 1'b0;

      at_edge(245);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending: got %0d unseen expected changes (next at cyc %0d) required 0",
                  exp_q.size(), exp_q[0].cyc);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pll_sequencer.md
# pll_sequencer

Startup and supervision controller for the on-chip rPLL. It runs from the free-running 27 MHz crystal clock and pulses the PLL reset, then qualifies LOCK, holding the downstream system reset until lock has been stable for a programmed time. It then applies runtime phase-shift (PSDA) changes through a req/ack handshake and restarts the PLL when lock is lost. It sits between the top level and the rPLL wrapper, and owns the PLL RESET, PSDA and DUTYDA inputs.

## Interface
- RESET_PULSE_CYCLES, 16: cycles pll_reset is held high per reset attempt (≥1).
- LOCK_TIMEOUT_CYCLES, 65535: cycles to wait for lock before retrying (≥1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (≥1).
- SETTLE_CYCLES, 8: wait after a PSDA change before phase_ack (≥1).
- DUTYDA_INIT, 4'b1000: constant driven on pll_dutyda.
- clk  in  1  27 MHz reference clock (never a PLL output).
- reset  in  1  synchronous, active-high.
- pll_lock  in  1  rPLL LOCK; asynchronous to clk.
- pll_reset  out  1  to rPLL RESET.
- pll_psda  out  4  to rPLL PSDA.
- pll_dutyda  out  4  to rPLL DUTYDA; constant DUTYDA_INIT.
- phase_req  in  1  phase-change request (level).
- phase_val  in  4  requested PSDA value.
- phase_ack  out  1  one-cycle pulse when the phase change has settled.
- sys_rst  out  1  active-high reset for logic clocked by the PLL outputs.
- locked  out  1  high only in RUN and PHASE.
- fault  out  1  sticky; set on any lock timeout.
- relock_cnt  out  8  count of lock losses from RUN or PHASE; saturates at 255.

## Operation
- pll_lock passes through a 2-FF synchronizer to produce lock_s. lock_s lags pll_lock by 2 cycles.
- One down-counter (width clog2 of the largest parameter) is shared by all states. It is reloaded on every state entry.
- States:
  - RST_PLL: pll_reset=1. Stays for RESET_PULSE_CYCLES cycles, then goes to WAIT_LOCK.
  - WAIT_LOCK: pll_reset=0.
    - lock_s=1 → STABLE.
    - Counter expires with lock_s=0 → set fault, go to RST_PLL (retry indefinitely).
  - STABLE: counts consecutive cycles with lock_s=1.
    - lock_s=0 → WAIT_LOCK, with a fresh timeout.
    - LOCK_STABLE_CYCLES consecutive high cycles → RUN.
  - RUN: sys_rst=0, locked=1.
    - lock_s=0 → RST_PLL and relock_cnt++. Lock loss takes priority over phase_req in the same cycle.
    - Otherwise phase_req=1 → PHASE, with phase_val captured into pll_psda on that edge.
  - PHASE: sys_rst=0, locked=1. Counts SETTLE_CYCLES.
    - Expiry → phase_ack=1 for exactly one cycle, then RUN.
    - lock_s=0 before expiry → RST_PLL and relock_cnt++, with no ack. pll_psda keeps the new value.
- Handshake:
  - Requester holds phase_req and phase_val stable until phase_ack.
  - Requester drops phase_req the cycle after ack. If phase_req is still high on the cycle after ack, it is taken as a new request.
  - phase_req outside RUN is not lost: it is serviced once RUN is reached.
- On every entry to RST_PLL:
  - sys_rst=1 and locked=0.
  - pll_psda is retained, so the PLL relocks with the last phase.
- reset:
  - Forces RST_PLL from any state on the next edge.
  - Clears fault, relock_cnt and pll_psda.

## Timing
- All outputs are registered.
- Reset values:
  - pll_reset=1, sys_rst=1, locked=0.
  - pll_psda=0, pll_dutyda=DUTYDA_INIT, phase_ack=0.
  - fault=0, relock_cnt=0.
- After reset falls at edge 0: pll_reset is high through edge RESET_PULSE_CYCLES and low after it.
- Lock to release: sys_rst falls on the same edge that enters RUN, LOCK_STABLE_CYCLES+2 cycles after pll_lock rises, given the 2-FF sync.
- Lock loss to reset: sys_rst rises 3 edges after pll_lock falls (2 sync + 1 state).
- Phase change: pll_psda updates one edge after phase_req is sampled in RUN. phase_ack rises SETTLE_CYCLES edges after that.
- A glitch on pll_lock shorter than 1 cycle may be missed; that is acceptable.

## Structure
- Shared package pll_seq_pkg holds:
  - The state enum (RST_PLL, WAIT_LOCK, STABLE, RUN, PHASE).
  - DUTYDA_DEFAULT = 4'b1000.
  - The PSDA width constant (4).
- Sub-module sync2 (generic 2-FF synchronizer, parameterized width) provides lock_s. It is reusable for other asynchronous inputs.

## Test plan
Bench parameters: RESET_PULSE=4, TIMEOUT=32, STABLE=8, SETTLE=4.
- Clean startup: pll_lock rises 10 cycles after pll_reset falls → sys_rst falls exactly 10 cycles later; locked=1; fault=0.
- Timeout: pll_lock held 0 → pll_reset re-pulses every 36 cycles; fault=1 after the first expiry and stays set; sys_rst stays 1.
- Unstable lock: lock high 5 cycles, low 1, then high → release occurs 8+2 cycles after the final rise, not earlier.
- Phase request: phase_val=4'h6 in RUN → pll_psda=6 one cycle later; phase_ack pulses once 4 cycles after that; sys_rst stays 0.
- Lock loss during PHASE: drop pll_lock 1 cycle after the request → no ack; relock_cnt=1; sys_rst=1 within 3 cycles; pll_psda=6 after relock.
- Mid-operation reset: assert reset in RUN with relock_cnt=3 → next cycle pll_reset=1, sys_rst=1, relock_cnt=0, pll_psda=0.
